// File: rtl/nibble_rx.sv
// nibble_rx: framed serial-to-parallel receiver feeding the 4-bit vote/score checker.
// Frame: start(0), 4 data bits LSB first, parity, stop(1); sampled only on bit_en.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   bit_en, bit_in    bit strobe and serial line (idles high)
//   o, o_valid        registered nibble and its valid flag
//   o_ready           consumer accept; transfer on o_valid && o_ready
//   perr, ferr, ovr   one-cycle pulses: parity error, framing error, overrun
module nibble_rx #(
  parameter bit PARITY_ODD = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_en,
  input  logic       bit_in,
  output logic [3:0] o,
  output logic       o_valid,
  input  logic       o_ready,
  output logic       perr,
  output logic       ferr,
  output logic       ovr
);

  typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;

  state_t     state;
  logic [1:0] cnt;
  logic [3:0] shift;
  logic       perr_pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      shift        <= '0;
      perr_pending <= 1'b0;
      o            <= '0;
      o_valid      <= 1'b0;
      perr         <= 1'b0;
      ferr         <= 1'b0;
      ovr          <= 1'b0;
    end else begin
      perr <= 1'b0;
      ferr <= 1'b0;
      ovr  <= 1'b0;

      // A transfer frees the slot; a load later in this block overrides it.
      if (o_valid && o_ready)
        o_valid <= 1'b0;

      if (bit_en) begin
        case (state)
          IDLE: begin
            if (!bit_in) begin
              state <= DATA;
              cnt   <= '0;
            end
          end
          DATA: begin
            shift[cnt] <= bit_in;
            cnt        <= cnt + 2'd1;
            if (cnt == 2'd3)
              state <= PAR;
          end
          PAR: begin
            perr_pending <= ((^shift ^ bit_in) != PARITY_ODD);
            state        <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!bit_in) begin
              ferr <= 1'b1;
            end else if (perr_pending) begin
              perr <= 1'b1;
            end else if (!o_valid || o_ready) begin
              o       <= shift;
              o_valid <= 1'b1;
            end else begin
              ovr <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nibble_rx.sv
module tb_nibble_rx;
  localparam bit PARITY_ODD = 1'b1;

  logic       clk = 1'b0;
  logic       rst, bit_en, bit_in, o_ready;
  logic [3:0] o;
  logic       o_valid, perr, ferr, ovr;

  nibble_rx #(.PARITY_ODD(PARITY_ODD)) dut (
    .clk(clk), .rst(rst), .bit_en(bit_en), .bit_in(bit_in),
    .o(o), .o_valid(o_valid), .o_ready(o_ready),
    .perr(perr), .ferr(ferr), .ovr(ovr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: output slot and pulses, updated from frame-level knowledge.
  logic [3:0] exp_o;
  logic       exp_valid, exp_perr, exp_ferr, exp_ovr;
  logic       is_stop;
  logic [3:0] cur_data;
  logic       cur_par_ok;
  logic       ready_rand, ready_on_stop;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    logic       xfer;
    logic [3:0] n_o;
    logic       n_valid, n_p, n_f, n_v;
    if (ready_rand) o_ready = 1'($urandom_range(1, 0));
    xfer    = exp_valid && o_ready;
    n_o     = exp_o;
    n_valid = exp_valid && !xfer;
    n_p = 1'b0; n_f = 1'b0; n_v = 1'b0;
    if (rst) begin
      n_o = 4'b0000; n_valid = 1'b0;
    end else if (bit_en && is_stop) begin
      if (!bit_in)                   n_f = 1'b1;
      else if (!cur_par_ok)          n_p = 1'b1;
      else if (!exp_valid || xfer) begin n_o = cur_data; n_valid = 1'b1; end
      else                           n_v = 1'b1;
    end
    @(posedge clk);
    #1;
    exp_o = n_o; exp_valid = n_valid; exp_perr = n_p; exp_ferr = n_f; exp_ovr = n_v;
    check("o",       o,                   exp_o);
    check("o_valid", {3'b000, o_valid},   {3'b000, exp_valid});
    check("perr",    {3'b000, perr},      {3'b000, exp_perr});
    check("ferr",    {3'b000, ferr},      {3'b000, exp_ferr});
    check("ovr",     {3'b000, ovr},       {3'b000, exp_ovr});
  endtask

  // One strobed bit preceded by a random number of idle cycles with junk on bit_in.
  task automatic strobe(input logic b, input int gmin, input int gmax, input logic stop);
    int g;
    g = int'($urandom_range(gmax, gmin));
    repeat (g) begin
      bit_en = 1'b0; bit_in = 1'($urandom); is_stop = 1'b0;
      tick();
    end
    bit_en = 1'b1; bit_in = b; is_stop = stop;
    if (stop && ready_on_stop) o_ready = 1'b1;
    tick();
    if (stop && ready_on_stop) o_ready = 1'b0;
    bit_en = 1'b0; is_stop = 1'b0; bit_in = 1'b1;
  endtask

  task automatic send_frame(input logic [3:0] d, input logic bad_par, input logic stop,
                            input int gmin, input int gmax);
    logic p;
    p = (PARITY_ODD ? ~^d : ^d) ^ bad_par;
    cur_data = d; cur_par_ok = !bad_par;
    strobe(1'b0, gmin, gmax, 1'b0);
    for (int i = 0; i < 4; i++) strobe(d[i], gmin, gmax, 1'b0);
    strobe(p, gmin, gmax, 1'b0);
    strobe(stop, gmin, gmax, 1'b1);
  endtask

  initial begin
    rst = 1'b1; bit_en = 1'b0; bit_in = 1'b1; o_ready = 1'b0;
    is_stop = 1'b0; ready_rand = 1'b0; ready_on_stop = 1'b0;
    cur_data = 4'b0000; cur_par_ok = 1'b1;
    exp_o = 4'b0000; exp_valid = 1'b0; exp_perr = 1'b0; exp_ferr = 1'b0; exp_ovr = 1'b0;
    tick(); tick();
    check("reset_o", o, 4'b0000);
    rst = 1'b0;
    tick();

    // Good frame, bits 0,0,1,1,0,1,1
    o_ready = 1'b1;
    send_frame(4'b0110, 1'b0, 1'b1, 0, 0);
    check("good_o", o, 4'b0110);
    check("good_valid", {3'b000, o_valid}, 4'b0001);
    tick();

    // Parity error
    send_frame(4'b0110, 1'b1, 1'b1, 0, 0);
    check("perr_pulse", {3'b000, perr}, 4'b0001);
    tick();

    // Framing error, then a good frame
    send_frame(4'b1111, 1'b0, 1'b0, 0, 0);
    check("ferr_pulse", {3'b000, ferr}, 4'b0001);
    send_frame(4'b0001, 1'b0, 1'b1, 0, 0);
    check("after_ferr_o", o, 4'b0001);
    tick();

    // Backpressure and overrun
    o_ready = 1'b0;
    send_frame(4'b0011, 1'b0, 1'b1, 0, 1);
    send_frame(4'b1000, 1'b0, 1'b1, 0, 1);
    check("ovr_pulse", {3'b000, ovr}, 4'b0001);
    check("ovr_held_o", o, 4'b0011);
    o_ready = 1'b1;
    tick();
    check("drain_valid", {3'b000, o_valid}, 4'b0000);
    o_ready = 1'b0;

    // Transfer and load on the same edge
    send_frame(4'b0101, 1'b0, 1'b1, 0, 0);
    ready_on_stop = 1'b1;
    send_frame(4'b1110, 1'b0, 1'b1, 0, 0);
    ready_on_stop = 1'b0;
    check("simul_o", o, 4'b1110);
    check("simul_valid", {3'b000, o_valid}, 4'b0001);
    check("simul_ovr", {3'b000, ovr}, 4'b0000);

    // Reset after three data bits, with a word still held
    strobe(1'b0, 0, 0, 1'b0);
    strobe(1'b1, 0, 0, 1'b0);
    strobe(1'b0, 0, 0, 1'b0);
    strobe(1'b1, 0, 0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_valid", {3'b000, o_valid}, 4'b0000);
    check("rst_mid_o", o, 4'b0000);
    tick();

    // Sparse strobes: bit_en every third cycle
    o_ready = 1'b1;
    send_frame(4'b1010, 1'b0, 1'b1, 2, 2);
    check("sparse_o", o, 4'b1010);
    tick();

    // Randomized frames, random backpressure and gaps
    ready_rand = 1'b1;
    repeat (200) begin
      send_frame(4'($urandom), ($urandom_range(3, 0) == 0), ($urandom_range(4, 0) != 0), 0, 2);
      repeat ($urandom_range(2, 0)) begin
        bit_en = 1'($urandom); bit_in = 1'b1;
        tick();
      end
    end
    ready_rand = 1'b0;
    o_ready = 1'b1;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
